regfile_wr_sched: RTL and testbench

//  Write-port scheduler for the 32x32 register file. Shares the single write port
//  (RegWr/Rd/WrRegData) among NREQ requesters (e.g. ALU writeback, load return,

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wr_sched_rr_arbiter.sv | 32 +++
 rtl/regfile_wr_sched.sv | 129 ++++++++++++
 tb/tb_regfile_wr_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the register-file write scheduler.
package regfile_pkg;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int NUM_REGS = 2 ** AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above i_ptr, wrapping from N-1 to 0. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_gidx
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Rotate requests so bit 0 is the requester the pointer currently favours.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Scan from farthest to nearest offset so the nearest asserted request wins.
  always_comb begin
    o_grant = '0;
    o_gidx  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_gidx  = PW'((int'(i_ptr) + k) % N);
        o_grant = N'(1) << o_gidx;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file: round-robin sharing of the single
// write port among NREQ requesters, plus a zeroing sweep after reset or clr_req.
// Optional build macro WR_FWD_EN adds write-to-read forwarding compare ports.
module regfile_wr_sched
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = regfile_pkg::DW,
  parameter int AW   = regfile_pkg::AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               clr_req,
  output logic               busy,
  output logic               RegWr,
  output logic [AW-1:0]      Rd,
  output logic [DW-1:0]      WrRegData
`ifdef WR_FWD_EN
  ,
  input  logic [AW-1:0]      rd_addr_a,
  input  logic [AW-1:0]      rd_addr_b,
  output logic               fwd_hit_a,
  output logic               fwd_hit_b,
  output logic [DW-1:0]      fwd_data
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic [PW-1:0]   r_ptr;
  logic            r_busy;
  logic            r_wr;
  logic [AW-1:0]   r_rd;
  logic [DW-1:0]   r_data;

  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_gidx;
  logic            w_accept;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;

  // Requests only compete in RUN, and not in a cycle that starts a sweep.
  assign w_req    = req_valid & {NREQ{(r_state == ST_RUN) && !clr_req}};
  assign w_accept = |w_grant;
  assign req_ready = w_grant;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_gidx  (w_gidx)
  );

  // Select the granted requester's address and data (grant is one-hot or zero).
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_addr = w_addr | req_addr[i*AW +: AW];
        w_data = w_data | req_data[i*DW +: DW];
      end
    end
  end

  // Scheduler FSM with registered write-port outputs; busy lags the state by a
  // cycle so it covers exactly the cycles in which sweep writes are presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
      r_wr    <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else begin
      r_busy <= (r_state == ST_CLEAR);
      r_wr   <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_wr   <= 1'b1;
          r_rd   <= r_idx;
          r_data <= '0;
          r_idx  <= r_idx + 1'b1;
          if (r_idx == {AW{1'b1}}) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (clr_req) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
          end else if (w_accept) begin
            r_ptr <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
            // r0 is hardwired zero: the write is consumed but never issued.
            if (w_addr != '0) begin
              r_wr   <= 1'b1;
              r_rd   <= w_addr;
              r_data <= w_data;
            end
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign busy      = r_busy;
  assign RegWr     = r_wr;
  assign Rd        = r_rd;
  assign WrRegData = r_data;

`ifdef WR_FWD_EN
  // Readers see the write landing this cycle; sweep writes carry zero data.
  assign fwd_hit_a = r_wr && (r_rd == rd_addr_a) && (rd_addr_a != '0);
  assign fwd_hit_b = r_wr && (r_rd == rd_addr_b) && (rd_addr_b != '0);
  assign fwd_data  = r_data;
`endif

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed testbench for regfile_wr_sched with a scoreboard of expected
// write-port values. Define WR_FWD_EN to also exercise the forwarding ports.
module tb_regfile_wr_sched;

  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               clr_req;
  logic               busy;
  logic               RegWr;
  logic [AW-1:0]      Rd;
  logic [DW-1:0]      WrRegData;
`ifdef WR_FWD_EN
  logic [AW-1:0]      rd_addr_a;
  logic [AW-1:0]      rd_addr_b;
  logic               fwd_hit_a;
  logic               fwd_hit_b;
  logic [DW-1:0]      fwd_data;
`endif

  always #5 clk = ~clk;

  regfile_wr_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .clr_req   (clr_req),
    .busy      (busy),
    .RegWr     (RegWr),
    .Rd        (Rd),
    .WrRegData (WrRegData)
`ifdef WR_FWD_EN
    ,
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .fwd_hit_a (fwd_hit_a),
    .fwd_hit_b (fwd_hit_b),
    .fwd_data  (fwd_data)
`endif
  );

  typedef struct packed {
    logic          wr;
    logic          bsy;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic          m_run;
  int            m_idx;
  int            m_ptr;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int            n_chk;
  int            n_fail;
  logic [NREQ-1:0] rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_idx  = 0;
    m_ptr  = 0;
    m_rd   = '0;
    m_data = '0;
    sb.delete();
  endtask

  // Called shortly after a rising edge (or after reset release): drive one
  // cycle of stimulus, check ready, push the expectation, then check outputs.
  task automatic step(input logic [NREQ-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic clr,
                      output logic [NREQ-1:0] rdy_obs);
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] sh;
    logic [AW-1:0]   ga;
    logic [DW-1:0]   gd;
    exp_t            e;
    int              g;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    clr_req   = clr;
    #1;
    er     = '0;
    g      = -1;
    e.bsy  = !m_run;
    e.wr   = 1'b0;
    e.rd   = m_rd;
    e.data = m_data;
    if (!m_run) begin
      e.wr   = 1'b1;
      e.rd   = AW'(m_idx);
      e.data = '0;
      m_rd   = e.rd;
      m_data = '0;
      if (m_idx == 31) m_run = 1'b1;
      m_idx++;
    end else if (clr) begin
      m_run = 1'b0;
      m_idx = 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j  = (m_ptr + k) % NREQ;
        sh = v >> j;
        if (g < 0 && sh[0]) g = j;
      end
      if (g >= 0) begin
        er    = NREQ'(1) << g;
        m_ptr = (g + 1) % NREQ;
        ga    = AW'(req_addr >> (g * AW));
        gd    = DW'(req_data >> (g * DW));
        if (ga != '0) begin
          e.wr   = 1'b1;
          e.rd   = ga;
          e.data = gd;
          m_rd   = ga;
          m_data = gd;
        end
      end
    end
    chk("req_ready", req_ready, er);
    rdy_obs = req_ready;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("RegWr", RegWr, e.wr);
    chk("Rd", Rd, e.rd);
    chk("WrRegData", WrRegData, e.data);
    chk("busy", busy, e.bsy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_RegWr", RegWr, 1'b0);
    chk("rst_Rd", Rd, '0);
    chk("rst_WrRegData", WrRegData, '0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_req_ready", req_ready, '0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] alt[4];
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    clr_req   = 1'b0;
`ifdef WR_FWD_EN
    rd_addr_a = '0;
    rd_addr_b = '0;
`endif
    model_reset();
    do_reset();

    // Post-reset sweep: 32 zeroing writes, then idle.
    for (int k = 0; k < 32; k++) step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, rdy);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, rdy);
    chk("sweep_done_busy", busy, 1'b0);

    // Single write r5 = DEADBEEF, then idle.
    step(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, rdy);
    chk("single_grant", rdy, 2'b01);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, rdy);

    // Both requesters valid: grants alternate starting from the pointer (now 1).
    alt[0] = 2'b10; alt[1] = 2'b01; alt[2] = 2'b10; alt[3] = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 5'd10, 5'd11, 32'hA0A0A0A0, 32'hB1B1B1B1, 1'b0, rdy);
      chk("rr_alternate", rdy, alt[k]);
    end
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, rdy);

    // Write to r0 is accepted but not issued.
    step(2'b01, 5'd0, 5'd0, 32'h00001234, 32'h0, 1'b0, rdy);
    chk("r0_ready", rdy, 2'b01);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, rdy);
    chk("r0_no_write", RegWr, 1'b0);

    // Accept then clr_req: the accepted write still issues, then the sweep runs.
    step(2'b10, 5'd0, 5'd9, 32'h0, 32'hCAFE0009, 1'b0, rdy);
    chk("pre_clr_grant", rdy, 2'b10);
    step(2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 1'b1, rdy);
    for (int k = 0; k < 10; k++) step(2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 1'b0, rdy);

    // Reset mid-sweep restarts at index 0 and clears the pointer.
    do_reset();
    for (int k = 0; k < 32; k++) step(2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 1'b0, rdy);
    step(2'b11, 5'd3, 5'd4, 32'h33, 32'h44, 1'b0, rdy);
    chk("ptr_after_reset", rdy, 2'b01);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, rdy);

`ifdef WR_FWD_EN
    step(2'b01, 5'd7, 5'd0, 32'h77777777, 32'h0, 1'b0, rdy);
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd7;
    #1;
    chk("fwd_hit_a", fwd_hit_a, 1'b1);
    chk("fwd_hit_b", fwd_hit_b, 1'b1);
    chk("fwd_data", fwd_data, 32'h77777777);
    rd_addr_a = 5'd0;
    #1;
    chk("fwd_hit_a_r0", fwd_hit_a, 1'b0);
    step(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, rdy);
    rd_addr_b = 5'd7;
    #1;
    chk("fwd_hit_b_idle", fwd_hit_b, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
